// File: rtl/regfile_access_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : regfile_access_arbiter
// Description : Round-robin valid/ready arbiter sharing one register file
//               access path between the core datapath and the I/O/debug unit.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_access_arbiter #(
    parameter int NUM_REGS   = 10,
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  CLK,
    input  logic                  RST_n,
    input  logic                  Req_Valid_0,
    input  logic                  Req_Write_0,
    input  logic [ADDR_WIDTH-1:0] Req_Addr_0,
    input  logic [DATA_WIDTH-1:0] Req_Data_0,
    output logic                  Req_Ready_0,
    output logic                  Rsp_Valid_0,
    output logic [DATA_WIDTH-1:0] Rsp_Data_0,
    output logic                  Rsp_Err_0,
    input  logic                  Req_Valid_1,
    input  logic                  Req_Write_1,
    input  logic [ADDR_WIDTH-1:0] Req_Addr_1,
    input  logic [DATA_WIDTH-1:0] Req_Data_1,
    output logic                  Req_Ready_1,
    output logic                  Rsp_Valid_1,
    output logic [DATA_WIDTH-1:0] Rsp_Data_1,
    output logic                  Rsp_Err_1,
    output logic [ADDR_WIDTH-1:0] RF_Sel,
    output logic                  RF_WE,
    output logic [DATA_WIDTH-1:0] RF_WData,
    input  logic [DATA_WIDTH-1:0] RF_RData,
    output logic                  Busy
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_RESP   = 2'd2;

    localparam logic [ADDR_WIDTH:0] c_num_regs = (ADDR_WIDTH+1)'(NUM_REGS);

    logic [1:0]            r_state;
    logic                  r_last_grant;
    logic                  r_grant;
    logic                  r_write;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_data;
    logic [DATA_WIDTH-1:0] r_rsp_data;
    logic                  r_rsp_err;

    logic w_idle;
    logic w_any;
    logic w_grant;
    logic w_legal;
    logic w_resp0;
    logic w_resp1;

    assign w_idle  = (r_state == S_IDLE);
    assign w_any   = Req_Valid_0 | Req_Valid_1;
    // On a tie the requester that did not win last time is served.
    assign w_grant = (Req_Valid_0 & Req_Valid_1) ? ~r_last_grant : Req_Valid_1;
    assign w_legal = ({1'b0, r_addr} < c_num_regs);

    assign Req_Ready_0 = w_idle & w_any & ~w_grant;
    assign Req_Ready_1 = w_idle & w_any &  w_grant;

    assign RF_Sel   = r_addr;
    assign RF_WData = r_data;
    // Gating with RST_n keeps a reset-sampling edge from committing a write.
    assign RF_WE    = (r_state == S_ACCESS) & r_write & w_legal & RST_n;
    assign Busy     = ~w_idle;

    assign w_resp0 = (r_state == S_RESP) & ~r_grant;
    assign w_resp1 = (r_state == S_RESP) &  r_grant;

    assign Rsp_Valid_0 = w_resp0;
    assign Rsp_Data_0  = w_resp0 ? r_rsp_data : '0;
    assign Rsp_Err_0   = w_resp0 & r_rsp_err;
    assign Rsp_Valid_1 = w_resp1;
    assign Rsp_Data_1  = w_resp1 ? r_rsp_data : '0;
    assign Rsp_Err_1   = w_resp1 & r_rsp_err;

    always_ff @(posedge CLK) begin
        if (!RST_n) begin
            r_state      <= S_IDLE;
            r_last_grant <= 1'b1;
            r_grant      <= 1'b0;
            r_write      <= 1'b0;
            r_addr       <= '0;
            r_data       <= '0;
            r_rsp_data   <= '0;
            r_rsp_err    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_grant      <= w_grant;
                        r_last_grant <= w_grant;
                        r_write      <= w_grant ? Req_Write_1 : Req_Write_0;
                        r_addr       <= w_grant ? Req_Addr_1  : Req_Addr_0;
                        r_data       <= w_grant ? Req_Data_1  : Req_Data_0;
                        r_state      <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    r_rsp_data <= (w_legal && !r_write) ? RF_RData : '0;
                    r_rsp_err  <= ~w_legal;
                    r_state    <= S_RESP;
                end
                S_RESP: begin
                    r_rsp_data <= '0;
                    r_rsp_err  <= 1'b0;
                    r_state    <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
